// File: rtl/user_io_pad_arbiter_if.sv
// Wishbone slave bundle for the user IO pad arbiter.
// Signal names follow the Caravel wbs_* naming, seen from the slave side.
interface user_io_pad_arbiter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/user_io_pad_arbiter.sv
// Per-pad ownership mux between the user core and a Wishbone GPIO bank.
// Owner changes float the affected pads for SETTLE_CYCLES before committing.
module user_io_pad_arbiter #(
  parameter logic [31:0]       BASE_ADDR     = 32'h3000_0000,
  parameter int                NUM_IO        = 38,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [NUM_IO-1:0] LOCK_MASK     = 38'h1F
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  user_io_pad_arbiter_if.slave wbs,
  input  logic [NUM_IO-1:0]    core_io_out,
  input  logic [NUM_IO-1:0]    core_io_oeb,
  output logic [NUM_IO-1:0]    core_io_in,
  input  logic [NUM_IO-1:0]    io_in,
  output logic [NUM_IO-1:0]    io_out,
  output logic [NUM_IO-1:0]    io_oeb,
  output logic                 switch_irq
);

  localparam int HI_W = NUM_IO - 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLOAT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [NUM_IO-1:0] owner_q, owner_d, gout_q, gout_d, goeb_q, goeb_d;
  logic [NUM_IO-1:0] pend_q, pend_d, chg_q, chg_d;
  logic [NUM_IO-1:0] sync_q, sync_d, gin_q, gin_d;
  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d, irq_q, irq_d;
  logic [31:0]       dat_q, dat_d;

  logic              decode, bus_req;
  logic [2:0]        word;
  logic [31:0]       rdata, merged;
  logic [NUM_IO-1:0] new_owner, owner_chg, flt;
  logic              unused_adr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  assign decode     = (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign word       = wbs.wbs_adr_i[4:2];
  assign bus_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & decode & ~ack_q;
  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  always_comb begin
    rdata = '0;
    case (word)
      3'd0: rdata = owner_q[31:0];
      3'd1: rdata[HI_W-1:0] = owner_q[NUM_IO-1:32];
      3'd2: rdata = gout_q[31:0];
      3'd3: rdata[HI_W-1:0] = gout_q[NUM_IO-1:32];
      3'd4: rdata = goeb_q[31:0];
      3'd5: rdata[HI_W-1:0] = goeb_q[NUM_IO-1:32];
      3'd6: rdata = gin_q[31:0];
      3'd7: begin
        rdata[HI_W-1:0] = gin_q[NUM_IO-1:32];
        rdata[31]       = (state_q != ST_IDLE);
      end
    endcase
  end

  // Byte-merge against the current register value so partial writes keep untouched lanes.
  always_comb begin
    merged    = merge_bytes(rdata, wbs.wbs_dat_i, wbs.wbs_sel_i);
    new_owner = owner_q;
    if (word == 3'd0) new_owner[31:0]        = merged;
    else              new_owner[NUM_IO-1:32] = merged[HI_W-1:0];
    new_owner = new_owner & ~LOCK_MASK;
    owner_chg = new_owner ^ owner_q;
  end

  always_comb begin
    owner_d = owner_q;
    gout_d  = gout_q;
    goeb_d  = goeb_q;
    pend_d  = pend_q;
    chg_d   = chg_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    irq_d   = 1'b0;
    dat_d   = '0;
    sync_d  = io_in;
    gin_d   = sync_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          if (!wbs.wbs_we_i) begin
            ack_d = 1'b1;
            dat_d = rdata;
          end else begin
            case (word)
              3'd0, 3'd1: begin
                if (owner_chg == '0) begin
                  ack_d = 1'b1;
                end else begin
                  pend_d  = new_owner;
                  chg_d   = owner_chg;
                  cnt_d   = 8'(SETTLE_CYCLES);
                  state_d = ST_FLOAT;
                end
              end
              3'd2: begin gout_d[31:0]        = merged;            ack_d = 1'b1; end
              3'd3: begin gout_d[NUM_IO-1:32] = merged[HI_W-1:0]; ack_d = 1'b1; end
              3'd4: begin goeb_d[31:0]        = merged;            ack_d = 1'b1; end
              3'd5: begin goeb_d[NUM_IO-1:32] = merged[HI_W-1:0]; ack_d = 1'b1; end
              default: ack_d = 1'b1;
            endcase
          end
        end
      end
      // Commit lands on the edge leaving FLOAT, so the COMMIT cycle shows new owner, ack and irq together.
      ST_FLOAT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_COMMIT;
          owner_d = pend_q;
          irq_d   = 1'b1;
          ack_d   = wbs.wbs_cyc_i & wbs.wbs_stb_i & wbs.wbs_we_i & decode & (word[2:1] == 2'b00);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      owner_q <= '0;
      gout_q  <= '0;
      goeb_q  <= '1;
      pend_q  <= '0;
      chg_q   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      dat_q   <= '0;
      sync_q  <= '0;
      gin_q   <= '0;
    end else begin
      owner_q <= owner_d;
      gout_q  <= gout_d;
      goeb_q  <= goeb_d;
      pend_q  <= pend_d;
      chg_q   <= chg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      dat_q   <= dat_d;
      sync_q  <= sync_d;
      gin_q   <= gin_d;
    end
  end

  assign flt = (state_q == ST_FLOAT) ? chg_q : '0;

  assign io_out = ~flt & ((owner_q & gout_q) | (~owner_q & core_io_out));
  assign io_oeb =  flt | (owner_q & goeb_q) | (~owner_q & core_io_oeb);

  assign core_io_in     = io_in;
  assign wbs.wbs_ack_o  = ack_q;
  assign wbs.wbs_dat_o  = dat_q;
  assign switch_irq     = irq_q;

endmodule
